lc3_operand_fetch: RTL and testbench
====================================

Name: lc3_operand_fetch

Overview:
- Operand-fetch/issue stage directly upstream of the LC-3 ALU.
- Accepts ADD/AND/NOT instruction words over a valid/ready handshake and decodes them into the ALU operation code.
- Reads the 8x16 general register file and registers Ra, Rb, the ALU op code, IR[5:0] and the destination register for the ALU.
- Owns the writeback port into the register file, plus a per-register pending scoreboard that stalls RAW/WAW hazards.

Parameters:
- NREGS, 8, number of general registers; fixed by the ISA and not intended to change.
- WIDTH, 16, datapath width.

Ports:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction word is present.
- in_instr  input  16  LC-3 instruction word.
- in_ready  output  1  stage accepts in_instr this cycle.
- out_valid  output  1  issued operation is held on the outputs.
- out_ready  input  1  ALU/writeback consumes the output this cycle.
- out_ra  output  16  register value of SR1 (instr[8:6]).
- out_rb  output  16  register value of SR2 (instr[2:0]).
- out_alu_control  output  2  00 pass-A, 01 ADD, 10 AND, 11 NOT.
- out_ir  output  6  instr[5:0]; bit 5 selects immediate, bits 4:0 are imm5.
- out_dr  output  3  destination register (instr[11:9]).
- wb_en  input  1  writeback strobe.
- wb_dr  input  3  writeback register index.
- wb_data  input  16  writeback value.
- illegal_op  output  1  one-cycle pulse when a non-ALU opcode is consumed.

Behaviour:
- Reset (async assert, sync-free deassert):
  - R0..R7 = 0, pending[7:0] = 0.
  - out_valid = 0; out_ra, out_rb = 0; out_alu_control = 00; out_ir = 0; out_dr = 0; illegal_op = 0.
  - Reset mid-operation discards the held output and all pending bits.
- Decode on opcode instr[15:12]:
  - 0001 → control 01.
  - 0101 → control 10.
  - 1001 → control 11.
  - Any other opcode is illegal.
- Source usage:
  - SR1 is used by all three ops.
  - SR2 is used only when the op is ADD/AND and instr[5] = 0.
  - NOT never uses SR2.
- Hazard, evaluated only while in_valid is high and the opcode is legal:
  - A hazard exists if a used source, or DR, has its pending bit set and is not cleared this cycle.
  - "Cleared this cycle" means wb_en = 1 and wb_dr equals that register.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard.
  - Accept = in_valid & in_ready.
  - in_ready is combinational. in_valid must not depend combinationally on in_ready.
- Legal accept, with the registers updated at the clock edge:
  - out_valid <= 1.
  - out_ra/out_rb get the register values, with a write-first bypass: if wb_en and wb_dr == the source index, wb_data is used instead.
  - out_rb is loaded with R[instr[2:0]] even when SR2 is unused; it is don't-care downstream but must still be deterministic.
  - out_ir <= instr[5:0]; out_dr <= instr[11:9]; pending[DR] <= 1.
- Illegal accept:
  - The instruction is consumed; out_valid and the scoreboard are unchanged apart from normal drain.
  - illegal_op = 1 for exactly that cycle.
- Drain: out_valid & out_ready & !accept → out_valid <= 0. Back-to-back accept with drain is full throughput (1 issue per cycle).
- Stall hold: out_valid & !out_ready holds all out_* stable, bit for bit.
- Writeback:
  - wb_en writes R[wb_dr] <= wb_data and clears pending[wb_dr].
  - If the same cycle issues an instruction with DR == wb_dr, the set wins and pending stays 1.
  - A writeback to a register that is not pending is legal and simply writes.
- Latency: instruction to out_valid is 1 cycle, or 1 cycle after the hazard resolves.
- Widths: no arithmetic in this stage; the imm5 sign extension is left to the ALU.

Test Plan:
- Reset, then drive wb writes R1 = 0x0005 and R2 = 0x0003. Then issue ADD R3,R1,R2 (0x1642) → next cycle out_valid = 1, out_ra = 0x0005, out_rb = 0x0003, control = 01, out_ir = 0x02, out_dr = 3; pending[3] = 1.
- RAW stall: with pending[3] set, present AND R4,R3,#7 (0x58E7) → in_ready = 0. Pulse wb_en, wb_dr = 3, wb_data = 0x0008 → accepted in that same cycle with out_ra = 0x0008 (bypass) and control = 10.
- Immediate and NOT paths:
  - ADD R0,R0,#-1 (0x103F) with pending[2] = 1 → no stall (SR2 unused), out_ir = 0x3F.
  - NOT R5,R6 (0x9BBF) → control = 11, no dependence on instr[2:0].
- Backpressure: hold out_ready = 0 for 3 cycles with a second instruction valid → outputs stable and in_ready = 0. Raise out_ready → second instruction issues the same cycle, with no bubble.
- Illegal opcode: present 0x0E02 (BR) → consumed in 1 cycle, illegal_op single pulse, out_valid and pending unchanged.
- Async reset: assert rst_n low mid-stall with pending ≠ 0 → out_valid = 0, pending = 0 and all registers read 0x0000 after release.

Source files
------------

// File: rtl/lc3_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : lc3_operand_fetch
// Description : LC-3 operand fetch / issue stage ahead of the ALU, with an
//               8x16 register file, writeback port and pending scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_operand_fetch #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ra,
    output logic [WIDTH-1:0] out_rb,
    output logic [1:0]       out_alu_control,
    output logic [5:0]       out_ir,
    output logic [2:0]       out_dr,
    input  logic             wb_en,
    input  logic [2:0]       wb_dr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             illegal_op
);

    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [1:0] c_CTL_PASS = 2'b00;
    localparam logic [1:0] c_CTL_ADD  = 2'b01;
    localparam logic [1:0] c_CTL_AND  = 2'b10;
    localparam logic [1:0] c_CTL_NOT  = 2'b11;

    logic [WIDTH-1:0] r_regFile [NREGS];
    logic [NREGS-1:0] r_pending;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outRa;
    logic [WIDTH-1:0] r_outRb;
    logic [1:0]       r_outCtl;
    logic [5:0]       r_outIr;
    logic [2:0]       r_outDr;
    logic             r_illegalOp;

    logic             w_legal;
    logic [1:0]       w_aluCtl;
    logic [2:0]       w_sr1;
    logic [2:0]       w_sr2;
    logic [2:0]       w_dr;
    logic             w_useSr2;
    logic [NREGS-1:0] w_wbMask;
    logic [NREGS-1:0] w_setMask;
    logic [NREGS-1:0] w_busy;
    logic             w_hazard;
    logic             w_accept;
    logic             w_issue;
    logic [WIDTH-1:0] w_raData;
    logic [WIDTH-1:0] w_rbData;

    assign w_sr1 = in_instr[8:6];
    assign w_sr2 = in_instr[2:0];
    assign w_dr  = in_instr[11:9];

    always_comb begin
        w_legal  = 1'b1;
        w_aluCtl = c_CTL_PASS;
        case (in_instr[15:12])
            c_OP_ADD: w_aluCtl = c_CTL_ADD;
            c_OP_AND: w_aluCtl = c_CTL_AND;
            c_OP_NOT: w_aluCtl = c_CTL_NOT;
            default:  w_legal  = 1'b0;
        endcase
    end

    assign w_useSr2 = w_legal & (w_aluCtl != c_CTL_NOT) & ~in_instr[5];

    // A register whose writeback lands this cycle no longer blocks issue.
    assign w_wbMask  = wb_en ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_dr) : '0;
    assign w_setMask = w_issue ? ({{(NREGS-1){1'b0}}, 1'b1} << w_dr) : '0;
    assign w_busy    = r_pending & ~w_wbMask;

    assign w_hazard = in_valid & w_legal &
                      (w_busy[w_sr1] | (w_useSr2 & w_busy[w_sr2]) | w_busy[w_dr]);

    assign in_ready = (~r_outValid | out_ready) & ~w_hazard;
    assign w_accept = in_valid & in_ready;
    assign w_issue  = w_accept & w_legal;

    assign w_raData = (wb_en && wb_dr == w_sr1) ? wb_data : r_regFile[w_sr1];
    assign w_rbData = (wb_en && wb_dr == w_sr2) ? wb_data : r_regFile[w_sr2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regFile[i] <= '0;
            end
            r_pending   <= '0;
            r_outValid  <= 1'b0;
            r_outRa     <= '0;
            r_outRb     <= '0;
            r_outCtl    <= c_CTL_PASS;
            r_outIr     <= '0;
            r_outDr     <= '0;
            r_illegalOp <= 1'b0;
        end else begin
            r_illegalOp <= w_accept & ~w_legal;
            // Set after clear: an issue to the register being written keeps it pending.
            r_pending   <= (r_pending & ~w_wbMask) | w_setMask;
            if (wb_en) begin
                r_regFile[wb_dr] <= wb_data;
            end
            if (w_issue) begin
                r_outValid <= 1'b1;
                r_outRa    <= w_raData;
                r_outRb    <= w_rbData;
                r_outCtl   <= w_aluCtl;
                r_outIr    <= in_instr[5:0];
                r_outDr    <= w_dr;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid       = r_outValid;
    assign out_ra          = r_outRa;
    assign out_rb          = r_outRb;
    assign out_alu_control = r_outCtl;
    assign out_ir          = r_outIr;
    assign out_dr          = r_outDr;
    assign illegal_op      = r_illegalOp;

endmodule
`default_nettype wire

// File: tb/tb_lc3_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_operand_fetch
// Description : Directed and randomized checks of lc3_operand_fetch against
//               an architectural model of registers, scoreboard and output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic [15:0] inInstr = '0;
    logic        outReady = 1'b0;
    logic        wbEn = 1'b0;
    logic [2:0]  wbDr = '0;
    logic [15:0] wbData = '0;

    logic        in_ready, out_valid, illegal_op;
    logic [15:0] out_ra, out_rb;
    logic [1:0]  out_alu_control;
    logic [5:0]  out_ir;
    logic [2:0]  out_dr;

    int checks = 0;
    int errors = 0;

    logic [15:0] mReg [8];
    bit          mPend [8];
    bit          mValid, mIll;
    logic [15:0] mRa, mRb;
    logic [1:0]  mCtl;
    logic [5:0]  mIr;
    logic [2:0]  mDr;

    logic [15:0] rIns;
    int          rPick;

    always #5 clk = ~clk;

    lc3_operand_fetch #(.NREGS(8), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_instr(inInstr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(outReady),
        .out_ra(out_ra), .out_rb(out_rb), .out_alu_control(out_alu_control),
        .out_ir(out_ir), .out_dr(out_dr),
        .wb_en(wbEn), .wb_dr(wbDr), .wb_data(wbData),
        .illegal_op(illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int opCtl(input logic [15:0] ins);
        case (ins[15:12])
            4'h1:    return 1;
            4'h5:    return 2;
            4'h9:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit busy(input int r);
        return mPend[r] && !(wbEn && int'(wbDr) == r);
    endfunction

    function automatic bit modelReady();
        int c;
        bit hz;
        c  = opCtl(inInstr);
        hz = 1'b0;
        if (inValid && c >= 0)
            hz = busy(int'(inInstr[8:6])) || busy(int'(inInstr[11:9])) ||
                 (c != 3 && !inInstr[5] && busy(int'(inInstr[2:0])));
        return (!mValid || outReady) && !hz;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mReg[i]  = '0;
            mPend[i] = 1'b0;
        end
        mValid = 0; mIll = 0; mRa = '0; mRb = '0; mCtl = '0; mIr = '0; mDr = '0;
    endtask

    task automatic modelStep(input bit rdy);
        int c;
        bit acc;
        logic [15:0] ra, rb;
        c   = opCtl(inInstr);
        acc = inValid && rdy;
        ra  = (wbEn && wbDr == inInstr[8:6]) ? wbData : mReg[inInstr[8:6]];
        rb  = (wbEn && wbDr == inInstr[2:0]) ? wbData : mReg[inInstr[2:0]];
        mIll = acc && c < 0;
        if (wbEn) begin
            mReg[wbDr]  = wbData;
            mPend[wbDr] = 1'b0;
        end
        if (acc && c >= 0) begin
            mValid = 1; mRa = ra; mRb = rb; mCtl = 2'(c);
            mIr = inInstr[5:0]; mDr = inInstr[11:9];
            mPend[inInstr[11:9]] = 1'b1;
        end else if (mValid && outReady) begin
            mValid = 0;
        end
    endtask

    task automatic checkOuts(input string tag);
        check({tag, "_valid"}, out_valid, mValid);
        check({tag, "_ra"}, out_ra, mRa);
        check({tag, "_rb"}, out_rb, mRb);
        check({tag, "_ctl"}, out_alu_control, mCtl);
        check({tag, "_ir"}, out_ir, mIr);
        check({tag, "_dr"}, out_dr, mDr);
        check({tag, "_illegal"}, illegal_op, mIll);
    endtask

    task automatic drive(input bit v, input logic [15:0] ins, input bit ordy,
                         input bit we, input logic [2:0] wd, input logic [15:0] wdat);
        inValid = v; inInstr = ins; outReady = ordy;
        wbEn = we; wbDr = wd; wbData = wdat;
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic cycle(input string tag);
        bit rdy;
        #2;
        rdy = modelReady();
        check({tag, "_in_ready"}, in_ready, rdy);
        modelStep(rdy);
        @(posedge clk);
        #1;
        checkOuts(tag);
    endtask

    task automatic expectReady(input string tag, input bit e);
        #1;
        check(tag, in_ready, e);
    endtask

    initial begin
        @(posedge clk);
        #1;
        modelReset();
        checkOuts("reset");
        rst_n = 1'b1;

        drive(0, 16'h0000, 1, 1, 3'd1, 16'h0005); cycle("wbR1");
        drive(0, 16'h0000, 1, 1, 3'd2, 16'h0003); cycle("wbR2");

        drive(1, 16'h1642, 0, 0, 3'd0, 16'h0000); cycle("add");
        check("add_valid_k", out_valid, 1'b1);
        check("add_ra_k", out_ra, 16'h0005);
        check("add_rb_k", out_rb, 16'h0003);
        check("add_ctl_k", out_alu_control, 2'b01);
        check("add_ir_k", out_ir, 6'h02);
        check("add_dr_k", out_dr, 3'd3);

        drive(1, 16'h58E7, 1, 0, 3'd0, 16'h0000);
        expectReady("raw_stall_k", 1'b0);
        cycle("raw_stall");
        drive(1, 16'h58E7, 1, 1, 3'd3, 16'h0008);
        expectReady("raw_release_k", 1'b1);
        cycle("raw_release");
        check("raw_bypass_ra_k", out_ra, 16'h0008);
        check("raw_ctl_k", out_alu_control, 2'b10);

        drive(1, 16'h1460, 1, 0, 3'd0, 16'h0000); cycle("setR2pend");
        drive(1, 16'h103F, 1, 0, 3'd0, 16'h0000);
        expectReady("imm_noStall_k", 1'b1);
        cycle("imm");
        check("imm_ir_k", out_ir, 6'h3F);
        drive(1, 16'h1262, 1, 0, 3'd0, 16'h0000);
        expectReady("imm2_noStall_k", 1'b1);
        cycle("imm2");

        drive(1, 16'h9BBF, 1, 0, 3'd0, 16'h0000); cycle("not");
        check("not_ctl_k", out_alu_control, 2'b11);
        drive(1, 16'h9F82, 1, 0, 3'd0, 16'h0000);
        expectReady("not_noSr2_k", 1'b1);
        cycle("not2");

        for (int k = 0; k < 3; k++) begin
            drive(1, 16'h5CC3, 0, 0, 3'd0, 16'h0000);
            expectReady("bp_ready_k", 1'b0);
            cycle("bp_hold");
            check("bp_dr_k", out_dr, 3'd7);
        end
        drive(1, 16'h5CC3, 1, 0, 3'd0, 16'h0000);
        expectReady("bp_release_k", 1'b1);
        cycle("bp_release");
        check("bp_issue_dr_k", out_dr, 3'd6);
        check("bp_issue_ra_k", out_ra, 16'h0008);

        drive(0, 16'h0000, 1, 0, 3'd0, 16'h0000); cycle("drain");
        drive(1, 16'h0E02, 1, 0, 3'd0, 16'h0000); cycle("illegal");
        check("illegal_pulse_k", illegal_op, 1'b1);
        check("illegal_valid_k", out_valid, 1'b0);
        drive(0, 16'h0000, 1, 0, 3'd0, 16'h0000); cycle("illegal_after");
        check("illegal_end_k", illegal_op, 1'b0);
        drive(1, 16'h1180, 1, 0, 3'd0, 16'h0000);
        expectReady("illegal_pendKept_k", 1'b0);
        cycle("pend_kept");

        drive(1, 16'h16E1, 0, 0, 3'd0, 16'h0000); cycle("pre_rst_issue");
        drive(1, 16'h1180, 0, 0, 3'd0, 16'h0000); cycle("pre_rst_stall");
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_k", out_valid, 1'b0);
        modelReset();
        checkOuts("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1, 16'h13C0, 1, 0, 3'd0, 16'h0000);
        expectReady("post_rst_r1_k", 1'b1);
        cycle("post_rst1");
        drive(1, 16'h1F85, 1, 0, 3'd0, 16'h0000);
        expectReady("post_rst_r6_k", 1'b1);
        cycle("post_rst2");
        drive(1, 16'h1103, 1, 0, 3'd0, 16'h0000); cycle("post_rst3");
        drive(1, 16'h1682, 1, 0, 3'd0, 16'h0000); cycle("post_rst4");
        check("post_rst_ra_k", out_ra, 16'h0000);
        check("post_rst_rb_k", out_rb, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            rIns  = 16'($urandom);
            rPick = $urandom_range(0, 9);
            if (rPick < 3)      rIns[15:12] = 4'h1;
            else if (rPick < 6) rIns[15:12] = 4'h5;
            else if (rPick < 9) rIns[15:12] = 4'h9;
            drive($urandom_range(0, 9) < 7, rIns, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
